// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer sharing one external 32x32->64 multiplier among NUM_REQ requesters.
// Optional macro MUL_SIGNED_EN adds per-request signed multiply (magnitudes in, product negated on exit).
module mul_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
`ifdef MUL_SIGNED_EN
    input  logic [NUM_REQ-1:0]    req_signed,
`endif
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [NUM_REQ*64-1:0] resp_y,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [63:0]           mul_y,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [31:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [MUL_LAT-1:0] stg_valid_q, stg_valid_d;
    logic [IDX_W-1:0]   stg_idx_q [MUL_LAT];
    logic [IDX_W-1:0]   stg_idx_d [MUL_LAT];
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [63:0]        resp_y_q [NUM_REQ];
    logic [63:0]        resp_y_d [NUM_REQ];
`ifdef MUL_SIGNED_EN
    logic [MUL_LAT-1:0] stg_neg_q, stg_neg_d;
    logic               neg_sel;
`endif

    logic [31:0]        a_arr [NUM_REQ];
    logic [31:0]        b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] eligible, grant;
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [31:0]        a_sel, b_sel, a_op, b_op;
    logic [63:0]        final_prod, fin_y;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign a_arr[g]           = req_a[32*g +: 32];
        assign b_arr[g]           = req_b[32*g +: 32];
        assign resp_y[64*g +: 64] = resp_y_q[g];
    end

    // Search starts one past the last accepted requester; a pending requester is skipped.
    always_comb begin
        eligible    = req_valid & ~pending_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!grant_found && eligible[IDX_W'((int'(last_grant_q) + off) % NUM_REQ)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'((int'(last_grant_q) + off) % NUM_REQ);
            end
        end
        grant = '0;
        if (grant_found && rst_n) grant[grant_idx] = 1'b1;
    end

    always_comb begin
        a_sel = a_arr[grant_idx];
        b_sel = b_arr[grant_idx];
        a_op  = a_sel;
        b_op  = b_sel;
`ifdef MUL_SIGNED_EN
        neg_sel = 1'b0;
        if (req_signed[grant_idx]) begin
            if (a_sel[31]) a_op = ~a_sel + 32'd1;
            if (b_sel[31]) b_op = ~b_sel + 32'd1;
            neg_sel = a_sel[31] ^ b_sel[31];
        end
`endif
    end

    // Stage 0 is the operand register; the multiplier output feeds MUL_LAT-1 product registers.
    if (MUL_LAT == 1) begin : g_lat1
        assign final_prod = mul_y;
    end else begin : g_pipe
        logic [63:0] prod_q [MUL_LAT-1];
        logic [63:0] prod_d [MUL_LAT-1];
        always_comb begin
            prod_d[0] = mul_y;
            for (int k = 1; k < MUL_LAT - 1; k++) prod_d[k] = prod_q[k-1];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < MUL_LAT - 1; k++) prod_q[k] <= '0;
            end else begin
                for (int k = 0; k < MUL_LAT - 1; k++) prod_q[k] <= prod_d[k];
            end
        end
        assign final_prod = prod_q[MUL_LAT-2];
    end

`ifdef MUL_SIGNED_EN
    assign fin_y = stg_neg_q[MUL_LAT-1] ? (~final_prod + 64'd1) : final_prod;
`else
    assign fin_y = final_prod;
`endif

    always_comb begin
        mul_a_d        = grant_found ? a_op : mul_a_q;
        mul_b_d        = grant_found ? b_op : mul_b_q;
        stg_valid_d[0] = grant_found;
        stg_idx_d[0]   = grant_idx;
`ifdef MUL_SIGNED_EN
        stg_neg_d[0]   = neg_sel;
`endif
        for (int k = 1; k < MUL_LAT; k++) begin
            stg_valid_d[k] = stg_valid_q[k-1];
            stg_idx_d[k]   = stg_idx_q[k-1];
`ifdef MUL_SIGNED_EN
            stg_neg_d[k]   = stg_neg_q[k-1];
`endif
        end
        last_grant_d = grant_found ? grant_idx : last_grant_q;
        pending_d    = (pending_q | grant) & ~(resp_valid_q & resp_ready);
        resp_valid_d = resp_valid_q & ~resp_ready;
        resp_y_d     = resp_y_q;
        // Buffer is guaranteed free here: its requester stayed pending since accept.
        if (stg_valid_q[MUL_LAT-1]) begin
            resp_valid_d[stg_idx_q[MUL_LAT-1]] = 1'b1;
            resp_y_d[stg_idx_q[MUL_LAT-1]]     = fin_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            stg_valid_q  <= '0;
            resp_valid_q <= '0;
`ifdef MUL_SIGNED_EN
            stg_neg_q    <= '0;
`endif
            for (int k = 0; k < MUL_LAT; k++) stg_idx_q[k] <= '0;
            for (int i = 0; i < NUM_REQ; i++) resp_y_q[i] <= '0;
        end else begin
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            stg_valid_q  <= stg_valid_d;
            resp_valid_q <= resp_valid_d;
`ifdef MUL_SIGNED_EN
            stg_neg_q    <= stg_neg_d;
`endif
            for (int k = 0; k < MUL_LAT; k++) stg_idx_q[k] <= stg_idx_d[k];
            for (int i = 0; i < NUM_REQ; i++) resp_y_q[i] <= resp_y_d[i];
        end
    end

    assign req_ready  = grant;
    assign resp_valid = resp_valid_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign busy       = |pending_q;

endmodule
